fp_mul_retire: RTL and testbench
================================

# fp_mul_retire

Result-retire stage directly downstream of the bfloat16 multiplier (`fp_mul`). It tracks which `fp_mul` output cycles carry a real result, using the multiplier's fixed one-cycle latency, and buffers those results with their exception flags in a small in-order FIFO. It exposes the results to the consumer through a valid/ready handshake and accumulates sticky exception flags. `fp_mul` cannot stall, so the block throttles the upstream issuer with a credit-style `issue_ready` and never drops a result.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CW`, $clog2(DEPTH+1): width of `count`.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  issuer presents an operand pair to `fp_mul` this cycle.
- `issue_ready`  out  1  issue permitted; an issue occurs only when `issue_valid && issue_ready`.
- `mul_product`  in  16  `fp_mul.product`.
- `mul_overflow`, `mul_underflow`, `mul_inexact`  in  1 each  `fp_mul` flags.
- `res_valid`  out  1  FIFO head holds a result.
- `res_ready`  in  1  consumer accepts head.
- `res_data`  out  16  head product.
- `res_flags`  out  3  head flags {overflow, underflow, inexact}.
- `sticky_flags`  out  3  OR of flags of all results written since reset or the last clear; same bit order.
- `flag_clear`  in  1  clear `sticky_flags`.
- `count`  out  CW  FIFO occupancy, 0..DEPTH.

## Operation
- `inflight` register: set to `issue_valid && issue_ready` every cycle. It marks that the `fp_mul` outputs are valid in the following cycle.
- Write: when `inflight`=1, store {`mul_product`, `mul_overflow`, `mul_underflow`, `mul_inexact`} at `wr_ptr`, then increment `wr_ptr` modulo DEPTH.
- Pop: when `res_valid && res_ready`, increment `rd_ptr` modulo DEPTH.
- `count`:
  - +1 on a write only.
  - −1 on a pop only.
  - Unchanged on a simultaneous write and pop, including at count=DEPTH−1 and at count=1.
- `issue_ready` = (`count` + `inflight`) < DEPTH. It is derived from registers only, with no combinational path from `issue_valid` or `res_ready`. Because of this credit rule, a write never occurs when `count`=DEPTH.
- `res_valid` = (`count` != 0). `res_data` and `res_flags` come from storage at `rd_ptr` and hold stable while `res_valid && !res_ready`.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full vs. empty is distinguished by `count` only.
- Sticky flags:
  - next = (`flag_clear` ? 0 : `sticky_flags`) | (`inflight` ? write flags : 0).
  - A flag written in the same cycle as a clear therefore survives.
- `fp_mul` has no reset, so its outputs are undefined until its first capture. They are ignored whenever `inflight`=0.
- Reset (asynchronous, `reset`=0):
  - `inflight`, pointers, `count`, `sticky_flags` and all storage entries go to 0.
  - Resulting outputs: `res_valid`=0, `res_data`=0, `res_flags`=0, `sticky_flags`=0, `count`=0, `issue_ready`=1.
  - Reset mid-operation discards buffered and in-flight results. The `fp_mul` output appearing after reset release is not written.
- Illegal: `issue_valid` high while `issue_ready` low is ignored (no issue counted). The issuer must not drive `fp_mul` that cycle.

## Timing
- Issue in cycle N → `fp_mul` output valid in N+1 → written at end of N+1 → `res_valid`=1 in N+2 when the FIFO was empty. Issue-to-result latency is 2 cycles.
- Throughput is 1 result/cycle with `res_ready` held high. Steady-state `count`=1.
- After a pop in cycle M frees a slot from full, `issue_ready` rises in M+1.
- With `res_ready`=0 from empty, exactly DEPTH issues are accepted. `issue_ready` falls in the cycle after the DEPTH-th issue, because `count`+`inflight` = DEPTH.
- Sticky update is visible the cycle after the write (N+2 for an issue in N).

## Test plan
- Reset: drive `reset`=0 mid-stream with `count`=2 and `inflight`=1, then release → `count`=0, `res_valid`=0, `sticky_flags`=000, `issue_ready`=1; the next `fp_mul` output is not written.
- Single op: issue opA=0x3F80, opB=0x4000 in cycle N → `res_valid`=1 in N+2, `res_data`=0x4000, `res_flags`=000; popped with `res_ready`=1 → `count`=0 in N+3.
- Fill/backpressure, DEPTH=4: `res_ready`=0, `issue_valid`=1 continuously → exactly 4 issues accepted, `issue_ready`=0 afterwards, `count`=4. Raise `res_ready` → 4 results in issue order, then `issue_ready` returns.
- Streaming: `res_ready`=1, 16 back-to-back issues with distinct products → 16 results in order, one per cycle; `count` never exceeds 1; `issue_ready` stays 1.
- Sticky: issue 0x7F00×0x7F00 (overflow) → `res_flags`=100, `sticky_flags`=100. Then `flag_clear` in the same cycle as writing an inexact-only result → `sticky_flags`=001.
- Wrap-around: 3×DEPTH+1 issues under random `res_ready` → ordering is preserved across pointer wrap; `count` never exceeds DEPTH; no write occurs at `count`=DEPTH.

Source files
------------

// File: rtl/fp_mul_retire_if.sv
// fp_mul_retire_if: issue credit, fp_mul capture, result handshake and sticky flags
// between the issuer/consumer side (master) and the retire stage (slave).
interface fp_mul_retire_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) ();
    logic          issue_valid;
    logic          issue_ready;
    logic [15:0]   mul_product;
    logic          mul_overflow;
    logic          mul_underflow;
    logic          mul_inexact;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   res_data;
    logic [2:0]    res_flags;
    logic [2:0]    sticky_flags;
    logic          flag_clear;
    logic [CW-1:0] count;

    modport master (
        output issue_valid, mul_product, mul_overflow, mul_underflow, mul_inexact,
               res_ready, flag_clear,
        input  issue_ready, res_valid, res_data, res_flags, sticky_flags, count
    );

    modport slave (
        input  issue_valid, mul_product, mul_overflow, mul_underflow, mul_inexact,
               res_ready, flag_clear,
        output issue_ready, res_valid, res_data, res_flags, sticky_flags, count
    );
endinterface

// File: rtl/fp_mul_retire.sv
// fp_mul_retire: captures fp_mul results one cycle after each issue into an in-order
// FIFO, throttles the issuer by credit and accumulates sticky exception flags.
module fp_mul_retire #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic            clk,
    input logic            rst_n,
    fp_mul_retire_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic          inflight_q, inflight_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    sticky_q, sticky_d;
    logic [18:0]   mem_q [DEPTH];
    logic          wr, pop;
    logic [2:0]    wr_flags;

    always_comb begin
        wr         = inflight_q;
        pop        = bus.res_valid && bus.res_ready;
        wr_flags   = {bus.mul_overflow, bus.mul_underflow, bus.mul_inexact};
        inflight_d = bus.issue_valid && bus.issue_ready;
        count_d    = (wr && !pop) ? count_q + CW'(1) :
                     (pop && !wr) ? count_q - CW'(1) : count_q;
        sticky_d   = (bus.flag_clear ? 3'b000 : sticky_q) | (wr ? wr_flags : 3'b000);
    end

    // Credit counts the in-flight product so a write can never land on a full FIFO.
    assign bus.issue_ready  = ((CW+1)'(count_q) + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
    assign bus.res_valid    = count_q != '0;
    assign bus.res_data     = mem_q[rd_ptr_q][18:3];
    assign bus.res_flags    = mem_q[rd_ptr_q][2:0];
    assign bus.sticky_flags = sticky_q;
    assign bus.count        = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sticky_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            if (wr) begin
                mem_q[wr_ptr_q] <= {bus.mul_product, wr_flags};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end
endmodule

// File: tb/tb_fp_mul_retire.sv
// tb_fp_mul_retire: directed vectors with hand-computed fp_mul products; a
// scoreboard queue holds expected results in issue order.
module tb_fp_mul_retire;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_mul_retire_if #(.DEPTH(DEPTH), .CW(CW)) bus ();
    fp_mul_retire #(.DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          errs = 0, checks = 0;
    logic [18:0] q[$];
    logic        pend_v = 1'b0;
    logic [18:0] pend = '0;
    int          exp_cnt = 0;
    logic [2:0]  exp_st = '0;
    int          n_acc = 0, n_pop = 0, max_cnt = 0;
    logic        ir_drop = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: fp_mul output reflects last accepted issue, otherwise garbage.
    task automatic tick(input logic iv, input logic rr, input logic fc,
                        input logic [15:0] prod, input logic [2:0] flg);
        logic acc, pop, wr;
        bus.issue_valid = iv;
        bus.res_ready   = rr;
        bus.flag_clear  = fc;
        {bus.mul_product, bus.mul_overflow, bus.mul_underflow, bus.mul_inexact} =
            pend_v ? pend : {16'hDEAD, 3'b111};
        #1;
        acc = iv && bus.issue_ready;
        pop = bus.res_valid && rr;
        wr  = pend_v;
        if (wr) check("no_wr_full", 32'(bus.count == CW'(DEPTH)), 0);
        if (pop) begin
            if (q.size() == 0) check("pop_empty", 32'(bus.res_valid), 0);
            else begin
                check("res_data", 32'(bus.res_data), 32'(q[0][18:3]));
                check("res_flags", 32'(bus.res_flags), 32'(q[0][2:0]));
                void'(q.pop_front());
                n_pop++;
            end
        end
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + int'(wr) - int'(pop);
        exp_st  = (fc ? 3'b000 : exp_st) | (wr ? pend[2:0] : 3'b000);
        if (acc) begin
            q.push_back({prod, flg});
            n_acc++;
        end
        pend_v = acc;
        pend   = {prod, flg};
        check("count", 32'(bus.count), 32'(exp_cnt));
        check("sticky", 32'(bus.sticky_flags), 32'(exp_st));
        check("issue_ready", 32'(bus.issue_ready), 32'((exp_cnt + int'(acc)) < DEPTH));
        check("res_valid", 32'(bus.res_valid), 32'(exp_cnt != 0));
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        if (!bus.issue_ready) ir_drop = 1'b1;
    endtask

    initial begin
        int n0, k, cyc;
        rst_n = 1'b0;
        bus.issue_valid = 1'b0;
        bus.res_ready   = 1'b0;
        bus.flag_clear  = 1'b0;
        {bus.mul_product, bus.mul_overflow, bus.mul_underflow, bus.mul_inexact} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(bus.count), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        check("rst_res_flags", 32'(bus.res_flags), 0);
        check("rst_sticky", 32'(bus.sticky_flags), 0);
        check("rst_issue_ready", 32'(bus.issue_ready), 1);
        rst_n = 1'b1;

        // Single op: 1.0 * 2.0 = 2.0
        tick(1, 0, 0, 16'h4000, 3'b000);
        tick(0, 0, 0, 16'h0000, 3'b000);
        check("single_valid", 32'(bus.res_valid), 1);
        check("single_data", 32'(bus.res_data), 32'h4000);
        check("single_flags", 32'(bus.res_flags), 0);
        tick(0, 1, 0, 16'h0000, 3'b000);
        check("single_count", 32'(bus.count), 0);

        // Fill with backpressure
        n0 = n_acc;
        for (int i = 0; i < 6; i++) tick(1, 0, 0, 16'h4100 + 16'(i), 3'b000);
        check("fill_accepted", 32'(n_acc - n0), DEPTH);
        check("fill_ready", 32'(bus.issue_ready), 0);
        check("fill_count", 32'(bus.count), DEPTH);
        tick(0, 1, 0, 16'h0000, 3'b000);
        check("fill_ready_back", 32'(bus.issue_ready), 1);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 16'h0000, 3'b000);
        check("fill_drained", 32'(bus.count), 0);

        // Streaming
        n0 = n_pop; max_cnt = 0; ir_drop = 1'b0;
        for (int i = 0; i < 16; i++) tick(1, 1, 0, 16'h3C00 + 16'(i * 3), 3'b000);
        tick(0, 1, 0, 16'h0000, 3'b000);
        tick(0, 1, 0, 16'h0000, 3'b000);
        check("stream_pops", 32'(n_pop - n0), 16);
        check("stream_max_count", 32'(max_cnt), 1);
        check("stream_ready_drop", 32'(ir_drop), 0);

        // Sticky: 0x7F00 * 0x7F00 overflows to +inf
        tick(1, 1, 0, 16'h7F80, 3'b100);
        tick(0, 1, 0, 16'h0000, 3'b000);
        check("ovf_flags", 32'(bus.res_flags), 32'b100);
        check("ovf_sticky", 32'(bus.sticky_flags), 32'b100);
        tick(1, 1, 0, 16'h3FAB, 3'b001);
        tick(0, 1, 1, 16'h0000, 3'b000);
        check("clear_survive", 32'(bus.sticky_flags), 32'b001);
        tick(0, 1, 0, 16'h0000, 3'b000);

        // Wrap-around under random backpressure
        k = 0; cyc = 0; max_cnt = 0;
        while (k < 3 * DEPTH + 1 && cyc < 300) begin
            n0 = n_acc;
            tick(1, 1'($urandom_range(0, 1)), 0, 16'h5000 + 16'(k), 3'(k));
            k += n_acc - n0;
            cyc++;
        end
        check("wrap_issued", 32'(k), 3 * DEPTH + 1);
        while (q.size() > 0 && cyc < 400) begin
            tick(0, 1, 0, 16'h0000, 3'b000);
            cyc++;
        end
        check("wrap_drained", 32'(q.size()), 0);
        check("wrap_max_le_depth", 32'(max_cnt <= DEPTH), 1);
        tick(0, 0, 1, 16'h0000, 3'b000);

        // Reset mid-stream with count=2, inflight=1
        tick(1, 0, 0, 16'h0080, 3'b010);
        tick(1, 0, 0, 16'h3F00, 3'b000);
        tick(1, 0, 0, 16'h4040, 3'b000);
        check("pre_rst_count", 32'(bus.count), 2);
        rst_n = 1'b0;
        #1;
        q.delete(); pend_v = 1'b0; exp_cnt = 0; exp_st = '0;
        check("mid_rst_count", 32'(bus.count), 0);
        check("mid_rst_valid", 32'(bus.res_valid), 0);
        check("mid_rst_sticky", 32'(bus.sticky_flags), 0);
        check("mid_rst_ready", 32'(bus.issue_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(0, 0, 0, 16'h0000, 3'b000);
        tick(0, 0, 0, 16'h0000, 3'b000);
        check("post_rst_count", 32'(bus.count), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
